// File: rtl/dup_range_param.sv
// Range generator: emits each value of the half-open range (base, limit, step) DUP times
// on a ready/valid stream, tagging each beat with its repetition index.
module dup_range_param #(
  parameter int WIDTH = 32,
  parameter int DUP   = 2,
  parameter int RW    = (DUP > 1) ? $clog2(DUP) : 1
) (
  input  logic                    _clock,
  input  logic                    _reset_n,
  input  logic                    _start,
  input  logic signed [WIDTH-1:0] base,
  input  logic signed [WIDTH-1:0] limit,
  input  logic signed [WIDTH-1:0] step,
  input  logic                    _ready,
  output logic                    _valid,
  output logic                    _done,
  output logic signed [WIDTH-1:0] _0,
  output logic        [RW-1:0]    _1
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_EMIT  = 2'd2;

  localparam logic [RW-1:0] REP_LAST = RW'(DUP - 1);

  logic [1:0]              state_q, state_d;
  logic signed [WIDTH-1:0] i_q, i_d;
  logic signed [WIDTH-1:0] lim_q, lim_d;
  logic signed [WIDTH-1:0] stp_q, stp_d;
  logic [RW-1:0]           rep_q, rep_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;
  logic signed [WIDTH-1:0] val_q, val_d;
  logic [RW-1:0]           idx_q, idx_d;

  logic             gate;
  logic             in_range;
  logic [WIDTH:0]   nxt;
  logic             ovf;

  assign gate = _ready || !valid_q;

  // Sign-bit tests avoid mixed-width comparisons against integer zero.
  assign in_range = (!stp_q[WIDTH-1] && (stp_q != '0) && (i_q < lim_q)) ||
                    ( stp_q[WIDTH-1] && (i_q > lim_q));

  assign nxt = {i_q[WIDTH-1], i_q} + {stp_q[WIDTH-1], stp_q};
  assign ovf = nxt[WIDTH] ^ nxt[WIDTH-1];

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    lim_d   = lim_q;
    stp_d   = stp_q;
    rep_d   = rep_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    val_d   = val_q;
    idx_d   = idx_q;

    if (_ready) begin
      valid_d = 1'b0;
    end

    if (_start) begin
      i_d     = base;
      lim_d   = limit;
      stp_d   = step;
      rep_d   = '0;
      state_d = S_CHECK;
    end else if (gate) begin
      case (state_q)
        S_IDLE: begin
          done_d = 1'b1;
        end
        S_CHECK: begin
          if (in_range) begin
            state_d = S_EMIT;
            rep_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_EMIT: begin
          val_d   = i_q;
          idx_d   = rep_q;
          valid_d = 1'b1;
          if (rep_q == REP_LAST) begin
            if (ovf) begin
              state_d = S_IDLE;
            end else begin
              i_d     = nxt[WIDTH-1:0];
              state_d = S_CHECK;
            end
          end else begin
            rep_d = rep_q + RW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge _clock) begin
    if (!_reset_n) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      lim_q   <= '0;
      stp_q   <= '0;
      rep_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      val_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      lim_q   <= lim_d;
      stp_q   <= stp_d;
      rep_q   <= rep_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      val_q   <= val_d;
      idx_q   <= idx_d;
    end
  end

  assign _valid = valid_q;
  assign _done  = done_q;
  assign _0     = val_q;
  assign _1     = idx_q;

endmodule

// File: tb/tb_dup_range_param.sv
// Bench for dup_range_param: two instances (32-bit/DUP=2 and 8-bit/DUP=3) checked
// beat by beat against a queue-based model of the duplicated range.
module tb_dup_range_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start_a, start_b, ready;
  logic signed [31:0] base_s, limit_s, step_s;

  logic               a_valid, a_done;
  logic signed [31:0] a_0;
  logic [0:0]         a_1;
  logic               b_valid, b_done;
  logic signed [7:0]  b_0;
  logic [1:0]         b_1;

  dup_range_param #(.WIDTH(32), .DUP(2)) u_a (
    ._clock(clk), ._reset_n(rst_n), ._start(start_a),
    .base(base_s), .limit(limit_s), .step(step_s),
    ._ready(ready), ._valid(a_valid), ._done(a_done), ._0(a_0), ._1(a_1)
  );

  dup_range_param #(.WIDTH(8), .DUP(3)) u_b (
    ._clock(clk), ._reset_n(rst_n), ._start(start_b),
    .base(base_s[7:0]), .limit(limit_s[7:0]), .step(step_s[7:0]),
    ._ready(ready), ._valid(b_valid), ._done(b_done), ._0(b_0), ._1(b_1)
  );

  int     checks = 0;
  int     errors = 0;
  longint exp_v[$];
  int     exp_r[$];
  int     idx = 0;
  bit     mon_en = 1'b0;
  bit     sel = 1'b0;

  // Expected beat list: every in-range value repeated dup times, stopping on overflow.
  function automatic void build_model(int w, int dup, longint b, longint l, longint s);
    longint i, nxt, maxv, minv;
    exp_v.delete();
    exp_r.delete();
    maxv = (longint'(1) << (w - 1)) - 1;
    minv = -(longint'(1) << (w - 1));
    i = b;
    while ((s > 0 && i < l) || (s < 0 && i > l)) begin
      for (int r = 0; r < dup; r++) begin
        exp_v.push_back(i);
        exp_r.push_back(r);
      end
      nxt = i + s;
      if (nxt > maxv || nxt < minv) break;
      i = nxt;
    end
  endfunction

  always @(negedge clk) begin : mon
    bit     v, d;
    longint val;
    int     rep;
    v   = sel ? b_valid : a_valid;
    d   = sel ? b_done : a_done;
    val = sel ? longint'(b_0) : longint'(a_0);
    rep = sel ? int'(b_1) : int'(a_1);
    if (mon_en && v) begin
      checks++;
      assert (idx < exp_v.size()) else begin
        errors++;
        $error("FAIL extra_beat got %0d/%0d beyond expected count %0d", val, rep, exp_v.size());
      end
      if (idx < exp_v.size()) begin
        checks++;
        assert (val === exp_v[idx] && rep === exp_r[idx]) else begin
          errors++;
          $error("FAIL beat%0d got %0d/%0d expected %0d/%0d", idx, val, rep, exp_v[idx], exp_r[idx]);
        end
      end
      checks++;
      assert (d === 1'b0) else begin
        errors++;
        $error("FAIL done_with_valid got done=%0b expected 0", d);
      end
      if (ready) idx++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(bit s, longint b, longint l, longint st);
    sel     = s;
    base_s  = b[31:0];
    limit_s = l[31:0];
    step_s  = st[31:0];
    start_a = !s;
    start_b = s;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // mode 0: ready high; 1: random ready; 2: five-cycle stall on the 4th beat
  task automatic run(bit s, longint b, longint l, longint st, int mode, string tag);
    bit fin = 1'b0;
    bit stalled = 1'b0;
    int stall = 0;
    build_model(s ? 8 : 32, s ? 3 : 2, b, l, st);
    idx    = 0;
    sel    = s;
    mon_en = 1'b1;
    ready  = 1'b1;
    pulse_start(s, b, l, st);
    for (int c = 0; c < 3000 && !fin; c++) begin
      if (mode == 1) begin
        ready = ($urandom_range(0, 3) != 0);
      end else if (mode == 2) begin
        if (!stalled && idx == 3 && (s ? b_valid : a_valid)) begin
          stalled = 1'b1;
          stall   = 5;
        end
        ready = (stall == 0);
        if (stall > 0) stall--;
      end
      tick();
      if ((s ? b_done : a_done) && idx == exp_v.size()) fin = 1'b1;
    end
    checks++;
    assert (fin) else begin
      errors++;
      $error("FAIL %s_complete got %0d beats expected %0d with done", tag, idx, exp_v.size());
    end
    ready = 1'b1;
    tick();
    checks++;
    assert ((s ? b_done : a_done) === 1'b1 && (s ? b_valid : a_valid) === 1'b0) else begin
      errors++;
      $error("FAIL %s_done_held got done=%0b valid=%0b expected 1/0", tag,
             s ? b_done : a_done, s ? b_valid : a_valid);
    end
  endtask

  task automatic empty_check(longint b, longint l, longint st);
    build_model(32, 2, b, l, st);
    idx    = 0;
    sel    = 1'b0;
    mon_en = 1'b1;
    ready  = 1'b1;
    pulse_start(1'b0, b, l, st);
    checks++;
    assert (a_done === 1'b0) else begin
      errors++; $error("FAIL empty_e0 got done=%0b expected 0", a_done);
    end
    tick();
    checks++;
    assert (a_done === 1'b0) else begin
      errors++; $error("FAIL empty_e1 got done=%0b expected 0", a_done);
    end
    tick();
    checks++;
    assert (a_done === 1'b1 && a_valid === 1'b0) else begin
      errors++; $error("FAIL empty_e2 got done=%0b valid=%0b expected 1/0", a_done, a_valid);
    end
  endtask

  initial begin
    bit saw;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; ready = 1'b1;
    base_s = '0; limit_s = '0; step_s = '0;
    tick();
    tick();
    checks++;
    assert (a_valid === 1'b0 && a_done === 1'b0 && a_0 === 32'sd0 && a_1 === 1'b0) else begin
      errors++; $error("FAIL reset_a got v=%0b d=%0b %0d/%0d expected 0 0 0/0", a_valid, a_done, a_0, a_1);
    end
    checks++;
    assert (b_valid === 1'b0 && b_done === 1'b0 && b_0 === 8'sd0 && b_1 === 2'd0) else begin
      errors++; $error("FAIL reset_b got v=%0b d=%0b %0d/%0d expected 0 0 0/0", b_valid, b_done, b_0, b_1);
    end
    rst_n = 1'b1;
    tick();
    tick();

    run(1'b0, 0, 10, 2, 0, "asc");
    run(1'b0, 10, 0, -3, 0, "desc");
    empty_check(5, 5, 1);
    empty_check(5, 0, 1);
    empty_check(0, 10, 0);
    run(1'b1, 1, 4, 1, 2, "backpressure");
    run(1'b1, 125, 127, 5, 0, "overflow");

    // Reset after the third beat of an ascending stream
    build_model(32, 2, 0, 10, 2);
    idx = 0; sel = 1'b0; mon_en = 1'b1; ready = 1'b1;
    pulse_start(1'b0, 0, 10, 2);
    for (int c = 0; c < 100 && idx < 3; c++) tick();
    checks++;
    assert (idx == 3) else begin
      errors++; $error("FAIL midreset_reach got %0d beats expected 3", idx);
    end
    mon_en = 1'b0;
    rst_n  = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    assert (a_valid === 1'b0 && a_0 === 32'sd0) else begin
      errors++; $error("FAIL midreset_valid got v=%0b val=%0d expected 0/0", a_valid, a_0);
    end
    saw = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      saw |= a_valid;
    end
    checks++;
    assert (!saw && a_done === 1'b1) else begin
      errors++; $error("FAIL midreset_quiet got sawvalid=%0b done=%0b expected 0/1", saw, a_done);
    end
    run(1'b0, 0, 4, 1, 0, "restart");

    // Reset asserted together with start
    mon_en = 1'b0;
    rst_n = 1'b0;
    base_s = 0; limit_s = 10; step_s = 1; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    rst_n = 1'b1;
    checks++;
    assert (a_valid === 1'b0 && a_done === 1'b0) else begin
      errors++; $error("FAIL rst_start_e0 got v=%0b d=%0b expected 0/0", a_valid, a_done);
    end
    tick();
    checks++;
    assert (a_valid === 1'b0 && a_done === 1'b1) else begin
      errors++; $error("FAIL rst_start_idle got v=%0b d=%0b expected 0/1", a_valid, a_done);
    end

    for (int k = 0; k < 8; k++) begin
      run(1'b0, longint'($urandom_range(0, 40)) - 20, longint'($urandom_range(0, 40)) - 20,
          longint'($urandom_range(0, 8)) - 4, 1, "rand_a");
    end
    for (int k = 0; k < 8; k++) begin
      run(1'b1, longint'($urandom_range(0, 255)) - 128, longint'($urandom_range(0, 255)) - 128,
          longint'($urandom_range(0, 100)) - 50, 1, "rand_b");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dup_range_param.md
# dup_range_param

Parametrised range generator that emits every value of the half-open integer range (base, limit, step) DUP times in succession over a ready/valid output stream. Each beat carries the value and its repetition index. It generalises the fixed two-repeat range generator: data width and repeat count are configurable, negative steps and empty ranges are handled, and overflow terminates the sequence cleanly. It sits in the func_call generator library as a callee for generated modules that consume duplicated range streams.

## Interface
- WIDTH, 32: signed width of base, limit, step and value output.
- DUP, 2: repeats per range value. Legal range is DUP ≥ 1.
- RW, $clog2(DUP) or 1 if DUP==1: width of the repetition-index output (derived; do not override).
- _clock  in  1  sole clock; all logic is on the rising edge.
- _reset_n  in  1  reset; synchronous, active-low.
- _start  in  1  capture base/limit/step this cycle and begin generating.
- base  in  WIDTH  signed first value.
- limit  in  WIDTH  signed exclusive bound.
- step  in  WIDTH  signed increment.
- _ready  in  1  consumer can accept a beat.
- _valid  out  1  _0/_1 hold a valid beat.
- _done  out  1  high while idle with no beat pending.
- _0  out  WIDTH  signed current value.
- _1  out  RW  repetition index, 0..DUP-1.

## Operation
- Reset values (_reset_n low at an edge): _valid=0, _done=0, _0=0, _1=0, rep=0, state=IDLE. Reset overrides _start and all state activity in the same cycle.
- Gate g = _ready || !_valid.
  - No state advances while g is low.
  - While _valid && !_ready, _0 and _1 hold.
  - If _ready is high and no new beat is produced, _valid clears at that edge.
- _done defaults to 0 each cycle. It is set to 1 only in IDLE when g is high.
- _start (with _reset_n high) takes effect regardless of g:
  - registers i<=base, limit, step, rep<=0, state<=CHECK, _done<=0.
  - A beat pending when _start arrives is not cancelled; _valid follows the normal g rule.
- States:
  - IDLE: set _done as above; hold.
  - CHECK (when g):
    - If (step>0 && i<limit) || (step<0 && i>limit), go to EMIT with rep<=0.
    - Otherwise go to IDLE. step==0 always goes to IDLE, giving an empty stream.
  - EMIT (when g): _0<=i, _1<=rep, _valid<=1.
    - If rep==DUP-1: compute nxt=i+step in WIDTH+1 bits. If nxt overflows WIDTH-bit signed range, go to IDLE. Else i<=nxt[WIDTH-1:0] and go to CHECK.
    - Else rep<=rep+1 and stay in EMIT.
- Comparisons are signed. There is no wrap-around: overflow always terminates the sequence.

## Timing
- _start at edge E0 → CHECK after E0.
  - Non-empty range: EMIT after E1; first _valid=1 after E2.
  - Empty range: IDLE after E1; _done=1 after E2.
- With _ready held high, each value takes DUP beat cycles plus one CHECK bubble. Steady-state throughput is DUP/(DUP+1) beats per cycle.
- A beat transfers at an edge where _valid && _ready.
- _done=1 is never asserted while a beat is still unaccepted. It requires IDLE and g.
- Reset mid-stream: _valid drops at the reset edge; no further beats until a new _start.

## Test plan
- Ascending stream: WIDTH=32, DUP=2, (0,10,2), _ready=1.
  - _0 = 0,0,2,2,4,4,6,6,8,8.
  - _1 = 0,1 alternating.
  - 10 beats, then _done=1 and held.
- Descending stream: DUP=2, (10,0,-3).
  - _0 = 10,10,7,7,4,4,1,1, then _done.
- Empty ranges: (5,5,1), (5,0,1) and (0,10,0).
  - Zero valid beats for each.
  - _done=1 exactly 2 edges after _start.
- Backpressure: DUP=3, (1,4,1). Drop _ready for 5 cycles at the 4th beat.
  - _0/_1 hold at 2/0 while _ready is low.
  - Full sequence is 1,1,1,2,2,2,3,3,3 with _1 = 0,1,2 repeating; no beat lost or duplicated.
- Overflow: WIDTH=8, DUP=3, (125,127,5).
  - Beats are 125,125,125, then _done.
  - 130 overflows, so there is no wrap to -126.
- Reset and restart: _reset_n low for one cycle after the 3rd beat of (0,10,2).
  - _valid=0 next edge; no beats until _start.
  - A fresh _start (0,4,1) yields 0,0,1,1,2,2,3,3.
  - _reset_n low together with _start leaves the block in reset IDLE.
